// File: rtl/inv_probe_ctrl.sv
// inv_probe_ctrl: toggles the analog inverter input and times the synchronized response.
// Rev 1.0 - initial release.
`default_nettype none

module inv_probe_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic             sense_in,
  output logic             drive_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] last_delay,
  output logic [CNT_W-1:0] max_delay
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_WAIT = 2'd1;
  localparam logic [1:0] C_GAP  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  logic [1:0]             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_remaining;
  logic                   w_sense_sync;
  logic                   w_match;
  logic [CNT_W-1:0]       w_delay;

  // Resets to 1 so the idle sense already reads as the inverse of drive 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sense_in};
    end
  end

  assign w_sense_sync = r_sync[SYNC_STAGES-1];
  assign w_match      = (w_sense_sync == ~drive_out);
  assign w_delay      = w_match ? r_cnt : C_TIMEOUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= C_IDLE;
      r_cnt       <= '0;
      r_remaining <= '0;
      drive_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      last_delay  <= '0;
      max_delay   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (start) begin
            err_count  <= '0;
            last_delay <= '0;
            max_delay  <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            if (num_toggles != '0) begin
              r_remaining <= num_toggles;
              drive_out   <= ~drive_out;
              r_cnt       <= '0;
              r_state     <= C_WAIT;
            end else begin
              r_state <= C_DONE;
            end
          end
        end
        C_WAIT: begin
          // A match wins over the timeout when both occur on the same count.
          if (w_match || (r_cnt == C_TIMEOUT)) begin
            if (!w_match && (err_count != '1)) begin
              err_count <= err_count + C_ONE;
            end
            last_delay <= w_delay;
            if (w_delay > max_delay) begin
              max_delay <= w_delay;
            end
            r_state <= C_GAP;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        C_GAP: begin
          r_remaining <= r_remaining - C_ONE;
          if (r_remaining == C_ONE) begin
            r_state <= C_DONE;
          end else begin
            drive_out <= ~drive_out;
            r_cnt     <= '0;
            r_state   <= C_WAIT;
          end
        end
        C_DONE: begin
          done    <= 1'b1;
          pass    <= (err_count == '0);
          busy    <= 1'b0;
          r_state <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inv_probe_ctrl.sv
// tb_inv_probe_ctrl: randomized runs against a delay-line / stuck-pin inverter model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_inv_probe_ctrl;
  localparam int SYNC = 2;
  localparam int TO   = 15;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] num_toggles;
  logic         sense_in;
  logic         drive_out, busy, done, pass;
  logic [W-1:0] err_count, last_delay, max_delay;

  int n_checks = 0;
  int n_fail   = 0;

  // Inverter model controls
  int   lag       = 0;
  bit   stuck     = 1'b0;
  bit   stuck_val = 1'b0;
  bit   m_drive   = 1'b0;
  logic hist[$];

  inv_probe_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT(TO), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_toggles(num_toggles),
    .sense_in(sense_in), .drive_out(drive_out), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .last_delay(last_delay),
    .max_delay(max_delay)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sense follows ~drive_out delayed by lag cycles, or sits at a stuck level.
  initial begin
    sense_in = 1'b1;
    for (int i = 0; i < 40; i++) hist.push_back(1'b0);
    forever begin
      @(posedge clk);
      #1;
      hist.push_front(drive_out);
      void'(hist.pop_back());
      sense_in = stuck ? stuck_val : ~hist[lag];
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_drive"}, drive_out, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_pass"},  pass, 0);
    chk({tag, "_err"},   err_count, 0);
    chk({tag, "_last"},  last_delay, 0);
    chk({tag, "_max"},   max_delay, 0);
  endtask

  task automatic run(input int n, input bit repulse, input int abort_at);
    bit   md;
    int   dl, exp_err, exp_last, exp_max, total, k, edges, busy_low, dones;
    logic prev;
    md = m_drive; exp_err = 0; exp_last = 0; exp_max = 0; total = 0;
    for (int i = 0; i < n; i++) begin
      md = ~md;
      if (stuck) begin
        dl = (stuck_val == ~md) ? 0 : TO;
        if (stuck_val != ~md) exp_err++;
      end else begin
        dl = lag + SYNC;
      end
      exp_last = dl;
      if (dl > exp_max) exp_max = dl;
      total += dl + 2;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    prev = drive_out;
    start = 1'b1;
    num_toggles = W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0; busy_low = 0;
    for (k = 0; k < 400; k++) begin
      if (k == 3) start = 1'b0;
      if (drive_out !== prev) edges++;
      prev = drive_out;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_low++;
      if (repulse && k == 2) begin
        start = 1'b1;
        num_toggles = 8'd5;
      end
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        dones = 0;
        repeat (30) begin
          @(posedge clk);
          #1;
          if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        m_drive = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("done_latency", k, total + 1);
    chk("edges", edges, n);
    chk("busy_during_run", busy_low, 0);
    chk("busy_after", busy, 0);
    chk("err_count", err_count, exp_err);
    chk("last_delay", last_delay, exp_last);
    chk("max_delay", max_delay, exp_max);
    chk("pass", pass, (exp_err == 0) ? 1 : 0);
    chk("drive_end", drive_out, md);
    @(posedge clk);
    #1;
    chk("done_single", done, 0);
    chk("pass_hold", pass, (exp_err == 0) ? 1 : 0);
    m_drive = md;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_toggles = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    lag = 0; stuck = 1'b0;
    run(4, 1'b0, -1);
    stuck = 1'b1; stuck_val = 1'b0;
    run(3, 1'b0, -1);
    stuck = 1'b0; lag = 5;
    run(3, 1'b0, -1);
    run(0, 1'b0, -1);
    lag = 0;
    run(4, 1'b1, -1);
    lag = 13;
    run(2, 1'b0, -1);
    lag = 5;
    run(4, 1'b0, 12);
    lag = 0;
    run(2, 1'b0, -1);

    for (int r = 0; r < 14; r++) begin
      lag       = $urandom_range(0, 13);
      stuck     = ($urandom_range(0, 3) == 0);
      stuck_val = 1'($urandom_range(0, 1));
      run($urandom_range(0, 10), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
